// File: rtl/census_disp_window_if.sv
// Pixel-stream bundle between the census producer and the disparity window feeder.
// The master side supplies census pairs; the slave side returns the candidate window.
interface census_disp_window_if #(
  parameter int censusVecW = 24,
  parameter int dispLevel  = 32,
  parameter int ImageW     = 640,
  parameter int ImageH     = 480
);
  localparam int XW = $clog2(ImageW);
  localparam int YW = $clog2(ImageH);

  logic                            in_valid;
  logic [censusVecW-1:0]           left_census;
  logic [censusVecW-1:0]           right_census;
  logic [censusVecW*dispLevel-1:0] LineData;
  logic [censusVecW-1:0]           PixData;
  logic                            IsOnEdge;
  logic                            out_valid;
  logic [XW-1:0]                   out_x;
  logic [YW-1:0]                   out_y;
  logic                            line_start;
  logic                            frame_end;

  modport master (
    output in_valid, left_census, right_census,
    input  LineData, PixData, IsOnEdge, out_valid, out_x, out_y, line_start, frame_end
  );

  modport slave (
    input  in_valid, left_census, right_census,
    output LineData, PixData, IsOnEdge, out_valid, out_x, out_y, line_start, frame_end
  );
endinterface

// File: rtl/census_disp_window.sv
// Per-line shift window of right census vectors feeding the SGM cost core, with
// raster position tracking and edge gating; one register stage from accept to output.
module census_disp_window #(
  parameter int censusVecW = 24,
  parameter int dispLevel  = 32,
  parameter int ImageW     = 640,
  parameter int ImageH     = 480,
  parameter int EdgeRows   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  census_disp_window_if.slave bus
);
  localparam int XW = $clog2(ImageW);
  localparam int YW = $clog2(ImageH);

  logic                  accept;
  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;
  logic                  x_last;
  logic                  y_last;
  logic [censusVecW-1:0] win_reg  [dispLevel];
  logic [censusVecW-1:0] win_next [dispLevel];

  logic [censusVecW-1:0] pix_reg;
  logic                  edge_reg;
  logic                  valid_reg;
  logic [XW-1:0]         out_x_reg;
  logic [YW-1:0]         out_y_reg;
  logic                  line_start_reg;
  logic                  frame_end_reg;

  assign accept = en && bus.in_valid;
  assign x_last = (x_reg == XW'(ImageW - 1));
  assign y_last = (y_reg == YW'(ImageH - 1));

  // A pixel at column 0 starts a fresh window so nothing leaks from the previous line.
  always_comb begin
    for (int d = 0; d < dispLevel; d++) begin
      win_next[d] = '0;
    end
    win_next[0] = bus.right_census;
    if (x_reg != '0) begin
      for (int d = 1; d < dispLevel; d++) begin
        win_next[d] = win_reg[d-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
      for (int d = 0; d < dispLevel; d++) begin
        win_reg[d] <= '0;
      end
    end else if (accept) begin
      for (int d = 0; d < dispLevel; d++) begin
        win_reg[d] <= win_next[d];
      end
      if (x_last) begin
        x_reg <= '0;
        y_reg <= y_last ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_reg        <= '0;
      edge_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      line_start_reg <= 1'b0;
      frame_end_reg  <= 1'b0;
    end else if (en) begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        pix_reg        <= bus.left_census;
        edge_reg       <= (int'(x_reg) < dispLevel - 1) || (int'(y_reg) < EdgeRows);
        out_x_reg      <= x_reg;
        out_y_reg      <= y_reg;
        line_start_reg <= (x_reg == '0);
        frame_end_reg  <= x_last && y_last;
      end
    end
  end

  // The window register already holds exactly what was presented on the last accept,
  // so it doubles as the LineData output stage.
  genvar gi;
  generate
    for (gi = 0; gi < dispLevel; gi++) begin : g_pack
      assign bus.LineData[gi*censusVecW +: censusVecW] = win_reg[gi];
    end
  endgenerate

  assign bus.PixData    = pix_reg;
  assign bus.IsOnEdge   = edge_reg;
  assign bus.out_valid  = valid_reg;
  assign bus.out_x      = out_x_reg;
  assign bus.out_y      = out_y_reg;
  assign bus.line_start = line_start_reg;
  assign bus.frame_end  = frame_end_reg;
endmodule

// File: tb/tb_census_disp_window.sv
// Randomized and directed bench for census_disp_window against a column-indexed line model.
module tb_census_disp_window;
  localparam int CW = 8;
  localparam int D  = 4;
  localparam int W  = 8;
  localparam int H  = 3;
  localparam int ER = 1;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  census_disp_window_if #(.censusVecW(CW), .dispLevel(D), .ImageW(W), .ImageH(H)) bus ();

  census_disp_window #(
    .censusVecW(CW), .dispLevel(D), .ImageW(W), .ImageH(H), .EdgeRows(ER)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: current raster position plus every right census seen so far on this line.
  int            mx, my;
  logic [CW-1:0] line_mem [W];
  logic [CW*D-1:0] e_line;
  logic [CW-1:0] e_pix;
  logic          e_edge, e_valid, e_ls, e_fe;
  int            e_x, e_y;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rs, input logic e, input logic iv,
                       input logic [CW-1:0] l, input logic [CW-1:0] r);
    if (rs) begin
      mx = 0; my = 0;
      for (int c = 0; c < W; c++) line_mem[c] = '0;
      e_line = '0; e_pix = '0; e_edge = 0; e_valid = 0;
      e_x = 0; e_y = 0; e_ls = 0; e_fe = 0;
    end else if (e) begin
      if (iv) begin
        if (mx == 0) for (int c = 0; c < W; c++) line_mem[c] = '0;
        line_mem[mx] = r;
        for (int d = 0; d < D; d++)
          e_line[d*CW +: CW] = (mx - d >= 0) ? line_mem[mx-d] : '0;
        e_pix   = l;
        e_x     = mx;
        e_y     = my;
        e_ls    = (mx == 0);
        e_fe    = (mx == W-1) && (my == H-1);
        e_edge  = (mx < D-1) || (my < ER);
        e_valid = 1'b1;
        mx = mx + 1;
        if (mx == W) begin
          mx = 0;
          my = (my + 1) % H;
        end
      end else begin
        e_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid",  64'(bus.out_valid),  64'(e_valid));
    check_eq("LineData",   64'(bus.LineData),   64'(e_line));
    check_eq("PixData",    64'(bus.PixData),    64'(e_pix));
    check_eq("IsOnEdge",   64'(bus.IsOnEdge),   64'(e_edge));
    check_eq("out_x",      64'(bus.out_x),      64'(e_x));
    check_eq("out_y",      64'(bus.out_y),      64'(e_y));
    check_eq("line_start", 64'(bus.line_start), 64'(e_ls));
    check_eq("frame_end",  64'(bus.frame_end),  64'(e_fe));
  endtask

  task automatic cycle(input logic rs, input logic e, input logic iv,
                       input logic [CW-1:0] l, input logic [CW-1:0] r);
    rst = rs; en = e;
    bus.in_valid = iv; bus.left_census = l; bus.right_census = r;
    @(posedge clk);
    #1;
    model(rs, e, iv, l, r);
    compare_all();
    $display("cyc rst=%0b en=%0b iv=%0b -> v=%0b (%0d,%0d) line=%h pix=%h edge=%0b ls=%0b fe=%0b",
             rs, e, iv, bus.out_valid, bus.out_x, bus.out_y, bus.LineData,
             bus.PixData, bus.IsOnEdge, bus.line_start, bus.frame_end);
  endtask

  // Pattern pixel driven from the reference position: right=10*y+x, left=0x80|x.
  task automatic pix(input logic e, input logic iv);
    cycle(1'b0, e, iv, CW'(8'h80 | mx), CW'(10*my + mx));
  endtask

  int pulses;
  int guard;

  initial begin
    cycle(1'b1, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 1'b1, '0, '0);

    // One full frame at one pixel per cycle, with hand-derived spot checks.
    pulses = 0;
    for (int k = 0; k < W*H; k++) begin
      pix(1'b1, 1'b1);
      if (bus.out_valid) pulses++;
      check_eq("frame_end_only_last", 64'(bus.frame_end), 64'(k == W*H-1));
      if (k == 13) begin
        check_eq("p51_line", 64'(bus.LineData), 64'h0C0D0E0F);
        check_eq("p51_pix",  64'(bus.PixData),  64'h85);
        check_eq("p51_edge", 64'(bus.IsOnEdge), 64'd0);
      end
      if (k == 16) begin
        check_eq("p02_line", 64'(bus.LineData),   64'h00000014);
        check_eq("p02_ls",   64'(bus.line_start), 64'd1);
      end
      if (k == 18) check_eq("p22_edge", 64'(bus.IsOnEdge), 64'd1);
      if (k == 6)  check_eq("p60_edge", 64'(bus.IsOnEdge), 64'd1);
      if (k == 11) check_eq("p31_edge", 64'(bus.IsOnEdge), 64'd0);
      if (k == 10) check_eq("p21_edge", 64'(bus.IsOnEdge), 64'd1);
    end
    check_eq("pulse_count", 64'(pulses), 64'd24);

    // Frame wrap: next pixel is (0,0) with a cleared window.
    pix(1'b1, 1'b1);
    check_eq("wrap_xy",   64'({bus.out_x, bus.out_y}), 64'd0);
    check_eq("wrap_ls",   64'(bus.line_start), 64'd1);
    check_eq("wrap_line", 64'(bus.LineData[CW*D-1:CW]), 64'd0);

    // Gaps in in_valid and a 3-cycle en stall mid-line.
    for (int k = 0; k < 32; k++) begin
      if (k >= 10 && k < 13) pix(1'b0, (k % 2) == 0);
      else                   pix(1'b1, (k % 4) == 0 || (k % 4) == 3);
    end

    // Reset in place of pixel (4,1).
    guard = 0;
    while (!(mx == 4 && my == 1) && guard < 100) begin
      pix(1'b1, 1'b1);
      guard++;
    end
    check_eq("reach_41", 64'(guard < 100), 64'd1);
    cycle(1'b1, 1'b1, 1'b1, 8'h84, 8'd14);
    check_eq("rst_zero", 64'({bus.out_valid, bus.LineData, bus.PixData, bus.IsOnEdge,
                              bus.out_x, bus.out_y, bus.line_start, bus.frame_end}), 64'd0);
    pix(1'b1, 1'b1);
    check_eq("post_rst_xy",   64'({bus.out_x, bus.out_y}), 64'd0);
    check_eq("post_rst_line", 64'(bus.LineData[CW*D-1:CW]), 64'd0);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 7, CW'($urandom), CW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/census_disp_window.md
Name: census_disp_window

Overview:
- Upstream feeder for the SGM cost/aggregation core.
- Accepts one left-image and one right-image census vector per pixel in raster order.
- Keeps a per-line shift window of the most recent dispLevel right-image census vectors.
- Each cycle, presents to the core:
  - LineData: all dispLevel disparity candidates.
  - PixData: the reference left census vector.
  - IsOnEdge: marks pixels whose cost must be gated to zero.
  - Raster position and frame markers, for downstream disparity writeback.

Parameters:
- censusVecW, 24, width of one census vector.
- dispLevel, 32, number of disparity candidates; a power of 2, ≥2, ≤ImageW.
- ImageW, 640, pixels per line.
- ImageH, 480, lines per frame.
- EdgeRows, 1, number of top rows flagged as edge.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global clock enable; when low, all state and outputs hold.
- in_valid  in  1  left_census/right_census are valid this cycle; no backpressure.
- left_census  in  censusVecW  left (reference) image census vector at the current raster position.
- right_census  in  censusVecW  right image census vector at the same raster position.
- LineData  out  censusVecW*dispLevel  slot d = right census at column x-d of the current line.
- PixData  out  censusVecW  left census at column x.
- IsOnEdge  out  1  cost gate for the SGM core.
- out_valid  out  1  outputs are valid this cycle.
- out_x  out  $clog2(ImageW)  column of the presented pixel.
- out_y  out  $clog2(ImageH)  row of the presented pixel.
- line_start  out  1  presented pixel has x==0.
- frame_end  out  1  presented pixel is (ImageW-1, ImageH-1).

Behaviour:
- Reset, synchronous (rst sampled at posedge clk, has priority over en):
  - x/y counters ← 0.
  - Shift window ← all zero.
  - All outputs ← 0.
- Accept condition: en && in_valid && !rst.
  - Pixel position is taken from the internal counters (x,y) before they advance.
- Counters, on accept:
  - x==ImageW-1: x←0; y←(y==ImageH-1)?0:y+1.
  - Otherwise x←x+1.
- Shift window W[0..dispLevel-1], on accept:
  - x==0: W[0]←right_census; W[1..dispLevel-1]←0. No data leaks across lines.
  - Otherwise: W[d]←W[d-1] for d≥1; W[0]←right_census.
- Output register: all outputs come from a single register stage (latency 1 cycle from accept). On accept:
  - LineData ← next value of W, with slot d at bits [d*censusVecW +: censusVecW].
  - PixData ← left_census.
  - out_x/out_y ← accepted position.
  - line_start ← (x==0).
  - frame_end ← (x==ImageW-1 && y==ImageH-1).
  - IsOnEdge ← (x < dispLevel-1) || (y < EdgeRows).
  - out_valid ← 1.
- No accept (en=1, in_valid=0): out_valid←0; all other outputs hold their last value.
- en=0: everything holds, including out_valid.
- Frame wrap: after frame_end the counters return to (0,0) with no extra cycles; back-to-back frames are supported at 1 pixel/cycle.
- Reset mid-line or mid-frame: the next accepted pixel is treated as (0,0); no partial-line data is retained.
- Counter widths: out_x/out_y are $clog2 of the dimension. ImageW/ImageH must not be powers of two larger than the width allows; the counters compare against ImageW-1/ImageH-1 explicitly and never rely on natural wrap.

Test Plan (bench overrides ImageW=8, ImageH=3, dispLevel=4, censusVecW=8, EdgeRows=1):
1. Reset then 1 frame, in_valid=1 every cycle, right_census=10*y+x, left_census=0x80|x:
   - Pixel (5,1): LineData slots 0..3 = 15,14,13,12; PixData=0x85; IsOnEdge=0.
   - Exactly 24 out_valid pulses.
2. Line boundary: at (0,2), LineData = {0,0,0,20} (slot0=20, slots 1–3 = 0); line_start=1; at (2,2), IsOnEdge=1.
3. Row 0, pixel (6,0): IsOnEdge=1 (EdgeRows). Pixel (3,1): IsOnEdge=0; (2,1): IsOnEdge=1.
4. Gaps: in_valid toggled 1,0,0,1 and en low for 3 cycles mid-line:
   - out_valid is 0 during in_valid gaps.
   - All outputs frozen while en=0.
   - Window contents and positions identical to the gap-free run.
5. frame_end is high only for (7,2). The next accepted pixel reports (0,0) with line_start=1 and a cleared window.
6. rst asserted for 1 cycle at pixel (4,1):
   - Next cycle all outputs are 0.
   - The following accepted pixel is reported at (0,0) with LineData slots 1–3 = 0.
